// File: rtl/ram_wb.sv
// Two-entry posted write buffer in front of the data-memory words RAM0..RAM7 and the IO64 output port.
// Writes commit in order one edge after acceptance at the earliest; HOLD freezes commits but not acceptance.
module ram_wb (
  input  logic        CLK_WB,
  input  logic        RESET,
  input  logic        WE,
  input  logic [7:0]  RAM_AD_IN,
  input  logic [15:0] RAM_DATA_IN,
  input  logic        HOLD,
  output logic        WB_READY,
  output logic [1:0]  PENDING,
  output logic [15:0] RAM0,
  output logic [15:0] RAM1,
  output logic [15:0] RAM2,
  output logic [15:0] RAM3,
  output logic [15:0] RAM4,
  output logic [15:0] RAM5,
  output logic [15:0] RAM6,
  output logic [15:0] RAM7,
  output logic [15:0] IO64_OUT,
  output logic        WR_ERR
);

  logic [7:0]  ad_q  [2];
  logic [15:0] dat_q [2];
  logic        wr_ptr_q;
  logic        rd_ptr_q;
  logic [1:0]  cnt_q;
  logic [1:0]  cnt_d;
  logic [15:0] ram_q [8];
  logic [15:0] io64_q;
  logic        err_q;

  logic        accept;
  logic        commit;
  logic [7:0]  head_ad;
  logic [15:0] head_dat;

  // Readiness depends only on the occupancy register, never on WE or HOLD.
  assign WB_READY = (cnt_q != 2'd2);
  assign accept   = WE && WB_READY;
  assign commit   = (cnt_q != 2'd0) && !HOLD;
  assign head_ad  = ad_q[rd_ptr_q];
  assign head_dat = dat_q[rd_ptr_q];

  always_comb begin
    cnt_d = cnt_q;
    if (accept && !commit) cnt_d = cnt_q + 2'd1;
    if (commit && !accept) cnt_d = cnt_q - 2'd1;
  end

  always_ff @(posedge CLK_WB) begin
    if (RESET) begin
      for (int i = 0; i < 8; i++) ram_q[i] <= 16'h0000;
      for (int i = 0; i < 2; i++) begin
        ad_q[i]  <= 8'h00;
        dat_q[i] <= 16'h0000;
      end
      io64_q   <= 16'h0000;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (commit) begin
        rd_ptr_q <= ~rd_ptr_q;
        if (head_ad[7:3] == 5'h00) ram_q[head_ad[2:0]] <= head_dat;
        else if (head_ad == 8'h40) io64_q <= head_dat;
        else err_q <= 1'b1;
      end
      if (accept) begin
        ad_q[wr_ptr_q]  <= RAM_AD_IN;
        dat_q[wr_ptr_q] <= RAM_DATA_IN;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      cnt_q <= cnt_d;
    end
  end

  assign PENDING  = cnt_q;
  assign RAM0     = ram_q[0];
  assign RAM1     = ram_q[1];
  assign RAM2     = ram_q[2];
  assign RAM3     = ram_q[3];
  assign RAM4     = ram_q[4];
  assign RAM5     = ram_q[5];
  assign RAM6     = ram_q[6];
  assign RAM7     = ram_q[7];
  assign IO64_OUT = io64_q;
  assign WR_ERR   = err_q;

endmodule

// File: tb/tb_ram_wb.sv
// Bench for ram_wb: directed scenarios with literal expectations, then random traffic
// compared every cycle against a queue-based model of the buffer and register file.
module tb_ram_wb;
  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        we_i = 1'b0;
  logic [7:0]  ad_i = 8'h00;
  logic [15:0] dat_i = 16'h0000;
  logic        hold_i = 1'b0;
  wire         rdy_o;
  wire  [1:0]  pend_o;
  wire  [15:0] ram_o [8];
  wire  [15:0] io64_o;
  wire         err_o;

  int n_chk = 0;
  int n_fail = 0;

  logic [23:0] mq[$];
  logic [15:0] m_ram [8];
  logic [15:0] m_io;
  logic        m_err;

  always #5 clk = ~clk;

  ram_wb dut (
    .CLK_WB(clk), .RESET(rst_i), .WE(we_i), .RAM_AD_IN(ad_i), .RAM_DATA_IN(dat_i),
    .HOLD(hold_i), .WB_READY(rdy_o), .PENDING(pend_o),
    .RAM0(ram_o[0]), .RAM1(ram_o[1]), .RAM2(ram_o[2]), .RAM3(ram_o[3]),
    .RAM4(ram_o[4]), .RAM5(ram_o[5]), .RAM6(ram_o[6]), .RAM7(ram_o[7]),
    .IO64_OUT(io64_o), .WR_ERR(err_o)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: the buffer is just a list of pending writes.
  task automatic model_edge(input logic rst, input logic we, input logic hold,
                            input logic [7:0] ad, input logic [15:0] dat);
    logic [23:0] e;
    bit room;
    if (rst) begin
      mq.delete();
      for (int i = 0; i < 8; i++) m_ram[i] = 16'h0000;
      m_io  = 16'h0000;
      m_err = 1'b0;
    end else begin
      room  = (mq.size() < 2);
      m_err = 1'b0;
      if (mq.size() > 0 && !hold) begin
        e = mq.pop_front();
        if (e[23:16] < 8) m_ram[e[18:16]] = e[15:0];
        else if (e[23:16] == 8'h40) m_io = e[15:0];
        else m_err = 1'b1;
      end
      if (we && room) mq.push_back({ad, dat});
    end
  endtask

  task automatic check_all();
    chk("pending", {14'b0, pend_o}, 16'(mq.size()));
    chk("wb_ready", {15'b0, rdy_o}, {15'b0, mq.size() < 2});
    chk("wr_err", {15'b0, err_o}, {15'b0, m_err});
    chk("io64", io64_o, m_io);
    for (int i = 0; i < 8; i++) chk($sformatf("ram%0d", i), ram_o[i], m_ram[i]);
  endtask

  task automatic step(input logic rst, input logic we, input logic hold,
                      input logic [7:0] ad, input logic [15:0] dat);
    @(negedge clk);
    rst_i = rst; we_i = we; hold_i = hold; ad_i = ad; dat_i = dat;
    model_edge(rst, we, hold, ad, dat);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
  endtask

  initial begin
    logic [7:0]  ra;
    logic [15:0] rd;
    logic [1:0]  sel;

    // Reset state
    step(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
    chk("rst_ready", {15'b0, rdy_o}, 16'h0001);
    chk("rst_pending", {14'b0, pend_o}, 16'h0000);

    // Basic write
    step(1'b0, 1'b1, 1'b0, 8'h03, 16'habcd);
    chk("basic_pend1", {14'b0, pend_o}, 16'h0001);
    chk("basic_ram3_early", ram_o[3], 16'h0000);
    idle();
    chk("basic_ram3", ram_o[3], 16'habcd);
    chk("basic_pend0", {14'b0, pend_o}, 16'h0000);

    // Full / stall
    step(1'b0, 1'b1, 1'b1, 8'h00, 16'h6535);
    step(1'b0, 1'b1, 1'b1, 8'h01, 16'h7628);
    step(1'b0, 1'b1, 1'b1, 8'h02, 16'h7e6e);
    chk("full_pend", {14'b0, pend_o}, 16'h0002);
    chk("full_ready", {15'b0, rdy_o}, 16'h0000);
    chk("full_ram0_held", ram_o[0], 16'h0000);
    idle();
    chk("drain_ram0", ram_o[0], 16'h6535);
    chk("drain_ram1_not_yet", ram_o[1], 16'h0000);
    idle();
    chk("drain_ram1", ram_o[1], 16'h7628);
    idle();
    chk("drain_ram2_dropped", ram_o[2], 16'h0000);

    // Unmapped then IO port
    step(1'b0, 1'b1, 1'b0, 8'h41, 16'h324f);
    step(1'b0, 1'b1, 1'b0, 8'h40, 16'h808d);
    chk("unmapped_err", {15'b0, err_o}, 16'h0001);
    chk("unmapped_io", io64_o, 16'h0000);
    idle();
    chk("io64_val", io64_o, 16'h808d);
    chk("err_one_cycle", {15'b0, err_o}, 16'h0000);

    // Simultaneous accept and commit
    step(1'b0, 1'b1, 1'b0, 8'h05, 16'h0000);
    chk("simul_pend_a", {14'b0, pend_o}, 16'h0001);
    step(1'b0, 1'b1, 1'b0, 8'h05, 16'h34b1);
    chk("simul_pend_b", {14'b0, pend_o}, 16'h0001);
    idle();
    chk("simul_ram5", ram_o[5], 16'h34b1);

    // Reset mid-operation with an unmapped entry still queued behind
    step(1'b0, 1'b1, 1'b1, 8'h07, 16'h64a6);
    step(1'b0, 1'b1, 1'b1, 8'h99, 16'h1111);
    chk("mid_pend2", {14'b0, pend_o}, 16'h0002);
    step(1'b1, 1'b1, 1'b0, 8'h06, 16'h2222);
    chk("mid_rst_pend", {14'b0, pend_o}, 16'h0000);
    chk("mid_rst_ready", {15'b0, rdy_o}, 16'h0001);
    chk("mid_rst_ram3", ram_o[3], 16'h0000);
    chk("mid_rst_io", io64_o, 16'h0000);
    idle();
    chk("mid_ram7", ram_o[7], 16'h0000);
    chk("mid_no_err", {15'b0, err_o}, 16'h0000);
    idle();
    chk("mid_no_err2", {15'b0, err_o}, 16'h0000);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      sel = 2'($urandom_range(0, 3));
      case (sel)
        2'd0, 2'd1: ra = 8'($urandom_range(0, 7));
        2'd2:       ra = ($urandom_range(0, 1) == 0) ? 8'h40 : 8'h41;
        default:    ra = 8'($urandom);
      endcase
      rd = 16'($urandom);
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 9) < 6),
           ($urandom_range(0, 9) < 4), ra, rd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ram_wb.md
RAM_WB -- requirements
Module: ram_wb

Interface
REQ-001 SHALL provide CLK_WB  in  1  single clock; all state updates on its rising edge.
REQ-002 SHALL provide RESET  in  1  synchronous, active-high reset.
REQ-003 SHALL provide WE  in  1  write request valid.
REQ-004 SHALL provide RAM_AD_IN  in  8  write address.
REQ-005 SHALL provide RAM_DATA_IN  in  16  write data.
REQ-006 SHALL provide HOLD  in  1  drain stall, asserted by the consumer while it samples RAM0..RAM7.
REQ-007 SHALL provide WB_READY  out  1  write buffer can accept this cycle.
REQ-008 SHALL provide PENDING  out  2  entries currently buffered (0..2).
REQ-009 SHALL provide RAM0..RAM7  out  16 each  data-memory words, consumed by the RAM decoder.
REQ-010 SHALL provide IO64_OUT  out  16  output-port register.
REQ-011 SHALL provide WR_ERR  out  1  one-cycle pulse on commit to an unmapped address.

Function
REQ-012 SHALL contain a 2-entry FIFO write buffer, each entry {8-bit address, 16-bit data}.
REQ-013 SHALL drive WB_READY = 1 iff PENDING < 2, computed from registered state only (no dependence on WE or HOLD).
REQ-014 SHALL accept an entry at a rising edge iff WE=1 and WB_READY=1; WE while WB_READY=0 SHALL be dropped silently.
REQ-015 SHALL commit the head entry at a rising edge iff PENDING > 0 and HOLD=0; one commit per cycle max.
REQ-016 SHALL make committed data visible on the target output immediately after the committing edge; minimum accept-to-visible latency 2 edges (accept at edge k, commit at edge k+1).
REQ-017 SHALL decode commit addresses: 0x00-0x07 -> RAM0..RAM7; 0x40 -> IO64_OUT; all other addresses (including 0x41, the read-only IO65 input) unmapped.
REQ-018 SHALL, on unmapped commit, leave all data registers unchanged, dequeue the entry, and assert WR_ERR for exactly the cycle following that edge.
REQ-019 SHALL hold WR_ERR at 0 in every cycle not immediately following an unmapped commit.
REQ-020 SHALL support simultaneous accept and commit in one edge; PENDING then stays constant and FIFO order is preserved.
REQ-021 SHALL commit entries strictly in acceptance order; two buffered writes to the same address SHALL leave the later data.
REQ-022 SHALL, while HOLD=1, keep RAM0..RAM7 and IO64_OUT stable and still accept writes while PENDING < 2.
REQ-023 SHALL update PENDING as PENDING + accept - commit, never exceeding 2 or underflowing 0.
REQ-024 SHALL use independent FIFO read/write pointers that wrap modulo 2.

Reset
REQ-025 SHALL, on RESET=1 at a rising edge, clear RAM0..RAM7 and IO64_OUT to 16'h0000, PENDING to 0, WR_ERR to 0, both pointers to 0; WB_READY reads 1 after that edge.
REQ-026 SHALL give RESET priority over WE and commit in the same edge; buffered entries SHALL be discarded, not committed.
REQ-027 SHALL produce no WR_ERR pulse for an unmapped entry flushed by reset.

Verification
REQ-028 Basic write: reset, then WE=1 with addr 0x03, data 16'habcd, HOLD=0 for one cycle -> PENDING=1 after edge 1, RAM3=16'habcd and PENDING=0 after edge 2, all other outputs 0.
REQ-029 Full/stall: HOLD=1, write 0x00=16'h6535, 0x01=16'h7628, 0x02=16'h7e6e on 3 consecutive cycles -> PENDING=2, WB_READY=0, third write dropped; release HOLD -> RAM0 then RAM1 update on successive edges, RAM2 remains 0.
REQ-030 Unmapped/IO: write 0x41=16'h324f then 0x40=16'h808d back to back -> WR_ERR high exactly one cycle after first commit, no register changes; IO64_OUT=16'h808d one edge later.
REQ-031 Simultaneous: PENDING=1 (HOLD=0), WE=1 each cycle with 0x05=16'h0000 then 0x05=16'h34b1 -> PENDING stays 1 throughout, RAM5 ends 16'h34b1.
REQ-032 Reset mid-operation: PENDING=2 with HOLD=1, pending entry to 0x07=16'h64a6, assert RESET with HOLD=0 and WE=1 -> after edge all outputs 0, PENDING=0, WB_READY=1, RAM7 never becomes 16'h64a6.
